// File: rtl/seq_shift_add_multiplier.sv
// Sequential shift-add multiplier (unsigned or two's-complement), one multiplier bit per cycle.
// Latency N cycles from accepted start to the done pulse; start is ignored while busy is high.
module seq_shift_add_multiplier #(
    parameter int M = 8,
    parameter int N = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [M-1:0]     A,
    input  logic [N-1:0]     B,
    output logic             busy,
    output logic             done,
    output logic [M+N-1:0]   C
);

    localparam int W  = M + N;
    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [M-1:0]    a_q, a_d;
    logic [N-1:0]    b_q, b_d;
    logic            sgn_q, sgn_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [IW-1:0]   i_q, i_d;
    logic [W-1:0]    c_q, c_d;

    logic [W-1:0]    ext_a;
    logic [W-1:0]    term;
    logic [W-1:0]    acc_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            acc_q   <= '0;
            i_q     <= '0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            acc_q   <= acc_d;
            i_q     <= i_d;
            c_q     <= c_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        acc_d   = acc_q;
        i_d     = i_q;
        c_d     = c_q;
        ext_a   = sgn_q ? {{N{a_q[M-1]}}, a_q} : {{N{1'b0}}, a_q};
        term    = ext_a << i_q;
        acc_nxt = acc_q;

        // MSB of a signed multiplier carries negative weight, so its term is subtracted.
        if (b_q[i_q]) begin
            if (sgn_q && (i_q == LAST)) begin
                acc_nxt = acc_q - term;
            end else begin
                acc_nxt = acc_q + term;
            end
        end

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    sgn_d   = signed_mode;
                    acc_d   = '0;
                    i_d     = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                acc_d = acc_nxt;
                if (i_q == LAST) begin
                    c_d     = acc_nxt;
                    state_d = DONE;
                end else begin
                    i_d = i_q + IW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign C    = c_q;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Bench for seq_shift_add_multiplier: directed spec vectors plus random operands vs arithmetic model.
module tb_seq_shift_add_multiplier;

    localparam int M = 8;
    localparam int N = 8;
    localparam int W = M + N;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           signed_mode;
    logic [M-1:0]   A;
    logic [N-1:0]   B;
    logic           busy;
    logic           done;
    logic [W-1:0]   C;

    int             err_cnt = 0;
    int             chk_cnt = 0;
    logic [W-1:0]   prev_c;

    seq_shift_add_multiplier #(.M(M), .N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_mode (signed_mode),
        .A           (A),
        .B           (B),
        .busy        (busy),
        .done        (done),
        .C           (C)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_mul(input logic [M-1:0] a, input logic [N-1:0] b,
                                             input logic s);
        longint sa, sb, p;
        sa = s ? longint'($signed(a)) : longint'(a);
        sb = s ? longint'($signed(b)) : longint'(b);
        p  = sa * sb;
        return p[W-1:0];
    endfunction

    // Waits for done after an accepted start, checking busy/C-hold each cycle; k = edges since accept.
    task automatic wait_done(output int k);
        k = 0;
        while (done !== 1'b1 && k < N + 4) begin
            chk("busy_run", busy, 1'b1);
            chk("c_hold", C, prev_c);
            @(negedge clk);
            k++;
        end
    endtask

    task automatic run_op(input logic [M-1:0] a, input logic [N-1:0] b, input logic s,
                          input logic [W-1:0] exp, input bit b2b);
        int k;
        if (!b2b) @(negedge clk);
        A = a; B = b; signed_mode = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        A = M'($urandom); B = N'($urandom); signed_mode = 1'($urandom);
        wait_done(k);
        chk("latency", k, N);
        chk("done", done, 1'b1);
        chk("busy_at_done", busy, 1'b0);
        chk("product", C, exp);
        prev_c = exp;
    endtask

    typedef struct {
        logic [M-1:0] a;
        logic [N-1:0] b;
        logic         s;
        logic [W-1:0] exp;
    } vec_t;

    vec_t dir_vecs[7];

    initial begin
        int k;
        logic [M-1:0] ra;
        logic [N-1:0] rb;
        logic         rs;

        dir_vecs[0] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
        dir_vecs[1] = '{8'hFF, 8'h01, 1'b1, 16'hFFFF};
        dir_vecs[2] = '{8'h80, 8'h7F, 1'b1, 16'hC080};
        dir_vecs[3] = '{8'h80, 8'h80, 1'b1, 16'h4000};
        dir_vecs[4] = '{8'hFF, 8'h01, 1'b0, 16'h00FF};
        dir_vecs[5] = '{8'h00, 8'hAB, 1'b0, 16'h0000};
        dir_vecs[6] = '{8'h5A, 8'h00, 1'b0, 16'h0000};

        rst = 1'b1; start = 1'b0; signed_mode = 1'b0; A = '0; B = '0;
        prev_c = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_c", C, 16'h0);
        rst = 1'b0;

        foreach (dir_vecs[i]) begin
            run_op(dir_vecs[i].a, dir_vecs[i].b, dir_vecs[i].s, dir_vecs[i].exp, 1'b0);
            @(negedge clk);
            chk("done_pulse_width", done, 1'b0);
            chk("idle_busy", busy, 1'b0);
        end

        // Operand change and extra start while busy must not disturb the operation.
        A = 8'd3; B = 8'd5; signed_mode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        repeat (3) begin
            @(negedge clk);
            k++;
        end
        A = 8'd9; B = 8'd7; signed_mode = 1'b1; start = 1'b1;
        @(negedge clk);
        k++;
        start = 1'b0;
        while (done !== 1'b1 && k < N + 4) begin
            @(negedge clk);
            k++;
        end
        chk("ign_latency", k, N);
        chk("ign_product", C, 16'h000F);
        prev_c = 16'h000F;

        // Back-to-back: start issued during the done cycle.
        run_op(8'd2, 8'd2, 1'b0, 16'h0004, 1'b1);

        // Reset mid-operation aborts without a done pulse.
        @(negedge clk);
        A = 8'h12; B = 8'h34; signed_mode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_c", C, 16'h0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        prev_c = '0;
        for (int j = 0; j < N + 3; j++) begin
            @(negedge clk);
            chk("no_done_after_abort", done, 1'b0);
        end
        run_op(8'h12, 8'h34, 1'b0, 16'h03A8, 1'b0);

        // Random operands, sometimes chained back-to-back.
        for (int n = 0; n < 60; n++) begin
            ra = M'($urandom);
            rb = N'($urandom);
            rs = 1'($urandom);
            if (n % 10 == 0) ra = {1'b1, {(M-1){1'b0}}};
            run_op(ra, rb, rs, ref_mul(ra, rb, rs), bit'($urandom_range(0, 1)));
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
